// File: rtl/bus_hold_arbiter_if.sv
// Bus-hold arbiter interface bundle.
// Groups the requester/processor handshake of bus_hold_arbiter:
//   req   : per-requester bus request (level)
//   hlda  : hold acknowledge from the processor bus interface
//   hold  : hold request to the processor
//   gnt   : one-hot (or zero) bus grant
//   busy  : arbiter not idle
//   err   : one-cycle pulse when HLDA is lost during a grant
// Modport 'slave' is the arbiter side; modport 'master' is the side that
// drives requests and the hold acknowledge.
interface bus_hold_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0] req;
    logic             hlda;
    logic             hold;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             err;

    modport slave (
        input  req,
        input  hlda,
        output hold,
        output gnt,
        output busy,
        output err
    );

    modport master (
        output req,
        output hlda,
        input  hold,
        input  gnt,
        input  busy,
        input  err
    );
endinterface

// File: rtl/bus_hold_arbiter.sv
// Bus-hold arbiter: asks the processor for the bus (HOLD/HLDA handshake) on
// behalf of N_REQ bus masters and hands it to one of them at a time,
// round-robin, for at most MAX_TENURE cycles per tenure. The bus always goes
// back to the processor (HOLD dropped, HLDA seen low) between two tenures.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   srst  : synchronous soft reset (same effect as rst_n, on the clock edge)
//   bus   : bus_hold_arbiter_if.slave (req, hlda in; hold, gnt, busy, err out)
module bus_hold_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_TENURE = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    bus_hold_arbiter_if.slave     bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HLDA = 3'd1,
        ST_GRANT     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_DROP = 3'd4
    } state_t;

    state_t           state_r;
    logic             hold_r;
    logic [N_REQ-1:0] gnt_r;
    logic             busy_r;
    logic             err_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] winner_r;
    logic [7:0]       count_r;
    logic [2:0]       turn_r;

    logic [PTR_W-1:0] winner_s;
    logic             found_s;
    logic [PTR_W-1:0] next_ptr_s;

    assign bus.hold = hold_r;
    assign bus.gnt  = gnt_r;
    assign bus.busy = busy_r;
    assign bus.err  = err_r;

    // Round-robin search: first asserted request at or above ptr_r, wrapping.
    always_comb begin
        int idx;
        winner_s = '0;
        found_s  = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_r) + i) % N_REQ;
            if (!found_s && bus.req[idx]) begin
                found_s  = 1'b1;
                winner_s = PTR_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pointer moves just past the requester that held the bus, wrapping at N_REQ-1.
    always_comb begin
        next_ptr_s = '0;
        if (winner_r == PTR_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_r + PTR_W'(1);
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            hold_r   <= 1'b0;
            gnt_r    <= '0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            ptr_r    <= '0;
            winner_r <= '0;
            count_r  <= 8'd0;
            turn_r   <= 3'd0;
        end else if (srst) begin
            state_r  <= ST_IDLE;
            hold_r   <= 1'b0;
            gnt_r    <= '0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            ptr_r    <= '0;
            winner_r <= '0;
            count_r  <= 8'd0;
            turn_r   <= 3'd0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|bus.req) begin
                        hold_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_WAIT_HLDA;
                    end
                end
                ST_WAIT_HLDA: begin
                    // No timeout: the processor decides when to release the bus.
                    if (bus.hlda) begin
                        if (found_s) begin
                            gnt_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                            winner_r <= winner_s;
                            count_r  <= 8'd1;
                            state_r  <= ST_GRANT;
                        end else begin
                            // Request withdrawn before HLDA: hand the bus straight back.
                            turn_r  <= 3'd1;
                            state_r <= ST_RELEASE;
                        end
                    end
                end
                ST_GRANT: begin
                    if (!bus.hlda) begin
                        // Processor took the bus back mid-tenure: abort without turnaround.
                        gnt_r   <= '0;
                        hold_r  <= 1'b0;
                        err_r   <= 1'b1;
                        ptr_r   <= next_ptr_s;
                        count_r <= 8'd0;
                        state_r <= ST_WAIT_DROP;
                    end else if (!bus.req[winner_r] || (count_r == 8'(MAX_TENURE))) begin
                        // count_r equals the number of GNT-high cycles already given.
                        gnt_r   <= '0;
                        ptr_r   <= next_ptr_s;
                        count_r <= 8'd0;
                        turn_r  <= 3'd1;
                        state_r <= ST_RELEASE;
                    end else begin
                        count_r <= count_r + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (turn_r == 3'(TURNAROUND)) begin
                        hold_r  <= 1'b0;
                        state_r <= ST_WAIT_DROP;
                    end else begin
                        turn_r <= turn_r + 3'd1;
                    end
                end
                ST_WAIT_DROP: begin
                    if (!bus.hlda) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hold_r  <= 1'b0;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    count_r <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Testbench for bus_hold_arbiter (N_REQ=4, MAX_TENURE=16, TURNAROUND=1).
// Stimulus pushes the expected tenures (grant vector, GNT-high length, ERR at
// the end) into a scoreboard queue; a monitor watching the bus pops and
// compares each tenure when it ends. A simple processor model returns HLDA
// a configurable number of cycles after HOLD.
module tb_bus_hold_arbiter;
    logic clk;
    logic rst_n;
    logic srst;

    bus_hold_arbiter_if #(.N_REQ(4)) bus ();

    bus_hold_arbiter #(
        .N_REQ      (4),
        .MAX_TENURE (16),
        .TURNAROUND (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (srst),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] gnt;
        int         len;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         hlda_dly  = 1;
    logic       hlda_auto = 1'b1;
    logic [7:0] hist_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Processor model: HLDA is HOLD delayed by hlda_dly cycles, or forced low.
    initial begin
        hist_r   = 8'd0;
        bus.hlda = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                hist_r = 8'd0;
            end else begin
                hist_r = {hist_r[6:0], bus.hold};
            end
            if (hlda_auto) begin
                bus.hlda = hist_r[hlda_dly];
            end else begin
                bus.hlda = 1'b0;
            end
        end
    end

    // Monitor: measures each grant tenure and checks it against the scoreboard.
    initial begin
        logic [3:0] cur;
        int         run_len;
        logic       hold_gap;
        exp_t       e;
        cur      = 4'd0;
        run_len  = 0;
        hold_gap = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur      = 4'd0;
                run_len  = 0;
                hold_gap = 1'b1;
            end else begin
                if (bus.gnt != 4'd0) begin
                    if (cur == 4'd0) begin
                        check("gnt_onehot", 32'($countones(bus.gnt)), 32'd1);
                        check("hold_gap_before_grant", 32'(hold_gap), 32'd1);
                        hold_gap = 1'b0;
                        cur      = bus.gnt;
                        run_len  = 1;
                    end else if (bus.gnt == cur) begin
                        run_len++;
                    end else begin
                        check("gnt_switch_without_gap", 32'(bus.gnt), 32'(cur));
                        cur     = bus.gnt;
                        run_len = 1;
                    end
                end else if (cur != 4'd0) begin
                    if (sb_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_tenure: gnt=%b len=%0d, none expected", cur, run_len);
                    end else begin
                        e = sb_q.pop_front();
                        check("tenure_gnt", 32'(cur), 32'(e.gnt));
                        check("tenure_len", 32'(run_len), 32'(e.len));
                        check("tenure_err", 32'(bus.err), 32'(e.err));
                    end
                    cur     = 4'd0;
                    run_len = 0;
                end
                if (!bus.hold) begin
                    hold_gap = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        while (bus.gnt == 4'd0 && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(bus.gnt != 4'd0), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic apply_reset();
        bus.req   = 4'd0;
        hlda_auto = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {28'd0, bus.hold, bus.busy, bus.err, |bus.gnt}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int   n;
        logic hold_seen;
        logic err_seen;
        rst_n   = 1'b0;
        srst    = 1'b0;
        bus.req = 4'd0;
        step();

        // Single request, HLDA two cycles after HOLD, five grant cycles.
        apply_reset();
        hlda_dly = 2;
        sb_q.push_back('{4'b0001, 5, 1'b0});
        bus.req = 4'b0001;
        n = 0;
        while (!bus.hlda && n < 20) begin
            step();
            n++;
        end
        check("single_hlda_seen", 32'(bus.hlda), 32'd1);
        check("single_no_gnt_before_hlda_edge", 32'(bus.gnt), 32'd0);
        step();
        check("single_gnt_after_hlda", 32'(bus.gnt), 32'b0001);
        repeat (4) step();
        bus.req = 4'b0000;
        step();
        check("single_release_gnt", 32'(bus.gnt), 32'd0);
        check("single_release_hold", 32'(bus.hold), 32'd1);
        step();
        check("single_hold_drop", 32'(bus.hold), 32'd0);
        wait_idle("single_idle");

        // Round robin with all four requesting: 16-cycle tenures, wrapping.
        apply_reset();
        hlda_dly = 1;
        sb_q.push_back('{4'b0001, 16, 1'b0});
        sb_q.push_back('{4'b0010, 16, 1'b0});
        sb_q.push_back('{4'b0100, 16, 1'b0});
        sb_q.push_back('{4'b1000, 16, 1'b0});
        sb_q.push_back('{4'b0001, 16, 1'b0});
        bus.req = 4'b1111;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("rr_all_tenures_seen", 32'(sb_q.size()), 32'd0);
        bus.req = 4'b0000;
        wait_idle("rr_idle");

        // Preemption: a single requester held for 40 cycles is cut at 16 and re-granted.
        apply_reset();
        hlda_dly = 1;
        sb_q.push_back('{4'b0100, 16, 1'b0});
        sb_q.push_back('{4'b0100, 16, 1'b0});
        bus.req = 4'b0100;
        repeat (40) step();
        bus.req = 4'b0000;
        wait_idle("preempt_idle");

        // HLDA lost in the third grant cycle: abort, ERR pulse, pointer advanced.
        apply_reset();
        hlda_dly = 1;
        sb_q.push_back('{4'b0001, 3, 1'b1});
        bus.req = 4'b0001;
        wait_gnt("loss_gnt_seen");
        step();
        hlda_auto = 1'b0;
        step();
        step();
        check("loss_gnt_cleared", 32'(bus.gnt), 32'd0);
        check("loss_hold_cleared", 32'(bus.hold), 32'd0);
        check("loss_err_pulse", 32'(bus.err), 32'd1);
        step();
        check("loss_err_one_cycle", 32'(bus.err), 32'd0);
        hlda_auto = 1'b1;
        sb_q.push_back('{4'b0010, 1, 1'b0});
        bus.req = 4'b1111;
        wait_gnt("loss_next_gnt_seen");
        check("loss_ptr_advanced", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
        wait_idle("loss_idle");

        // Request withdrawn before HLDA arrives: no grant, no error, back to idle.
        apply_reset();
        hlda_dly  = 3;
        hold_seen = 1'b0;
        err_seen  = 1'b0;
        bus.req   = 4'b0010;
        step();
        bus.req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            if (bus.hold) hold_seen = 1'b1;
            if (bus.err) err_seen = 1'b1;
            step();
        end
        check("withdraw_hold_raised", 32'(hold_seen), 32'd1);
        check("withdraw_no_err", 32'(err_seen), 32'd0);
        check("withdraw_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a grant, then search restarts at 0.
        apply_reset();
        hlda_dly = 1;
        bus.req  = 4'b1000;
        wait_gnt("rst_gnt_seen");
        check("rst_gnt_before", 32'(bus.gnt), 32'b1000);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {28'd0, bus.hold, bus.busy, bus.err, |bus.gnt}, 32'd0);
        bus.req = 4'b1001;
        step();
        step();
        rst_n = 1'b1;
        sb_q.push_back('{4'b0001, 1, 1'b0});
        wait_gnt("rst_regrant_seen");
        check("rst_first_grant_req0", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0000;
        wait_idle("rst_idle");

        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
